// File: rtl/lin1d_weight_sched.sv
// Weight sequencer for the 1D linear-interpolation datapath: ramps scale1 from 0
// toward ONE per accepted beat, gates the sample handshake and marks segment ends.
module lin1d_weight_sched #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned CNT_WIDTH  = 16,
  parameter int unsigned ONE        = 1024
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_cfg_valid,
  output logic                      o_cfg_ready,
  input  logic [DATA_WIDTH-1:0]     i_cfg_step,
  input  logic [CNT_WIDTH-1:0]      i_cfg_len,
  input  logic                      i_cfg_abort,
  input  logic                      i_in_tvalid,
  input  logic                      i_in_tlast,
  output logic                      o_in_tready,
  input  logic [2*DATA_WIDTH-1:0]   i_in0_tdata,
  input  logic [2*DATA_WIDTH-1:0]   i_in1_tdata,
  output logic                      o_dp_tvalid,
  output logic                      o_dp_tlast,
  input  logic                      i_dp_tready,
  output logic [DATA_WIDTH-1:0]     o_dp_scale0,
  output logic [DATA_WIDTH-1:0]     o_dp_scale1,
  output logic [2*DATA_WIDTH-1:0]   o_dp_in0_tdata,
  output logic [2*DATA_WIDTH-1:0]   o_dp_in1_tdata,
  output logic                      o_busy,
  output logic                      o_seg_done
);

  localparam int unsigned SUM_W = DATA_WIDTH + 1;

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [1:0]            r_rst_sync;
  logic [DATA_WIDTH-1:0] r_step;
  logic [CNT_WIDTH-1:0]  r_len;
  logic [CNT_WIDTH-1:0]  r_k;
  logic [DATA_WIDTH-1:0] r_w1;
  logic [DATA_WIDTH-1:0] r_w0;
  logic                  r_seg_done;

  logic                  w_cfg_take;
  logic                  w_beat;
  logic                  w_last;
  logic [SUM_W-1:0]      w_sum;
  logic [DATA_WIDTH-1:0] w_w1_next;
  logic [DATA_WIDTH-1:0] w_w0_next;

  // Reset asserts immediately; release is delayed two clocks before a segment may start.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_rst_sync <= 2'b00;
    else          r_rst_sync <= {r_rst_sync[0], 1'b1};
  end

  assign w_cfg_take = i_cfg_valid && (i_cfg_len != '0) && r_rst_sync[1];
  assign w_beat     = (r_state == S_RUN) && i_in_tvalid && i_dp_tready;
  assign w_last     = (r_k == (r_len - CNT_WIDTH'(1))) || i_in_tlast;

  // Widened add cannot wrap; clamp to unity.
  assign w_sum      = SUM_W'(r_w1) + SUM_W'(r_step);
  assign w_w1_next  = (w_sum >= SUM_W'(ONE)) ? DATA_WIDTH'(ONE) : w_sum[DATA_WIDTH-1:0];
  assign w_w0_next  = DATA_WIDTH'(ONE) - w_w1_next;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (w_cfg_take) w_state_next = S_RUN;
      S_RUN:  if ((w_beat && w_last) || i_cfg_abort) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    o_cfg_ready = 1'b0;
    o_busy      = 1'b0;
    o_in_tready = 1'b0;
    o_dp_tvalid = 1'b0;
    o_dp_tlast  = 1'b0;
    case (r_state)
      S_IDLE: o_cfg_ready = 1'b1;
      S_RUN: begin
        o_busy      = 1'b1;
        o_in_tready = i_dp_tready;
        o_dp_tvalid = i_in_tvalid;
        o_dp_tlast  = w_last;
      end
      default: o_cfg_ready = 1'b0;
    endcase
  end

  // Weights and beat counter; cleared whenever a segment ends so IDLE shows scale1 = 0.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_step     <= '0;
      r_len      <= '0;
      r_k        <= '0;
      r_w1       <= '0;
      r_w0       <= DATA_WIDTH'(ONE);
      r_seg_done <= 1'b0;
    end else begin
      r_seg_done <= (r_state == S_RUN) && (w_state_next == S_IDLE);
      if (r_state == S_IDLE) begin
        if (w_cfg_take) begin
          r_step <= i_cfg_step;
          r_len  <= i_cfg_len;
          r_k    <= '0;
          r_w1   <= '0;
          r_w0   <= DATA_WIDTH'(ONE);
        end
      end else if (w_state_next == S_IDLE) begin
        r_k  <= '0;
        r_w1 <= '0;
        r_w0 <= DATA_WIDTH'(ONE);
      end else if (w_beat) begin
        r_k  <= r_k + CNT_WIDTH'(1);
        r_w1 <= w_w1_next;
        r_w0 <= w_w0_next;
      end
    end
  end

  assign o_dp_scale1    = r_w1;
  assign o_dp_scale0    = r_w0;
  assign o_seg_done     = r_seg_done;
  assign o_dp_in0_tdata = i_in0_tdata;
  assign o_dp_in1_tdata = i_in1_tdata;

endmodule

// File: tb/tb_lin1d_weight_sched.sv
// Directed bench for lin1d_weight_sched: ramp, saturation, early tlast, stall,
// abort and reset scenarios with hand-computed weights.
module tb_lin1d_weight_sched;

  logic        clk;
  logic        rst_n;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [15:0] cfg_step;
  logic [15:0] cfg_len;
  logic        cfg_abort;
  logic        in_tvalid;
  logic        in_tlast;
  logic        in_tready;
  logic [31:0] in0_tdata;
  logic [31:0] in1_tdata;
  logic        dp_tvalid;
  logic        dp_tlast;
  logic        dp_tready;
  logic [15:0] dp_scale0;
  logic [15:0] dp_scale1;
  logic [31:0] dp_in0_tdata;
  logic [31:0] dp_in1_tdata;
  logic        busy;
  logic        seg_done;

  int n_cmp = 0;
  int n_err = 0;

  lin1d_weight_sched #(.DATA_WIDTH(16), .CNT_WIDTH(16), .ONE(1024)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_cfg_valid(cfg_valid), .o_cfg_ready(cfg_ready),
    .i_cfg_step(cfg_step), .i_cfg_len(cfg_len), .i_cfg_abort(cfg_abort),
    .i_in_tvalid(in_tvalid), .i_in_tlast(in_tlast), .o_in_tready(in_tready),
    .i_in0_tdata(in0_tdata), .i_in1_tdata(in1_tdata),
    .o_dp_tvalid(dp_tvalid), .o_dp_tlast(dp_tlast), .i_dp_tready(dp_tready),
    .o_dp_scale0(dp_scale0), .o_dp_scale1(dp_scale1),
    .o_dp_in0_tdata(dp_in0_tdata), .o_dp_in1_tdata(dp_in1_tdata),
    .o_busy(busy), .o_seg_done(seg_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change on the falling edge; outputs are sampled 1 ns later.
  task automatic drive(input logic v, input logic last, input logic rdy, input logic abrt);
    @(negedge clk);
    cfg_valid = 1'b0;
    in_tvalid = v;
    in_tlast  = last;
    dp_tready = rdy;
    cfg_abort = abrt;
    in0_tdata = $urandom;
    in1_tdata = $urandom;
    #1;
  endtask

  task automatic do_cfg(input logic [15:0] len, input logic [15:0] step);
    @(negedge clk);
    in_tvalid = 1'b0;
    in_tlast  = 1'b0;
    cfg_abort = 1'b0;
    cfg_valid = 1'b1;
    cfg_len   = len;
    cfg_step  = step;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cfg_valid = 1'b0; cfg_step = '0; cfg_len = '0; cfg_abort = 1'b0;
    in_tvalid = 1'b0; in_tlast = 1'b0; dp_tready = 1'b0; in0_tdata = '0; in1_tdata = '0;
    #12;
    n_cmp++;
    if ({cfg_ready, busy, in_tready, dp_tvalid, dp_tlast, seg_done} !== 6'b100000) begin
      n_err++; $display("FAIL reset_ctrl got=%b exp=100000", {cfg_ready, busy, in_tready, dp_tvalid, dp_tlast, seg_done});
    end
    n_cmp++;
    if (dp_scale1 !== 16'd0 || dp_scale0 !== 16'd1024) begin
      n_err++; $display("FAIL reset_scale got s1=%0d s0=%0d exp s1=0 s0=1024", dp_scale1, dp_scale0);
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_ramp();
    logic [15:0] exp1 [4] = '{16'd0, 16'd256, 16'd512, 16'd768};
    logic [15:0] exp0 [4] = '{16'd1024, 16'd768, 16'd512, 16'd256};
    do_cfg(16'd4, 16'd256);
    n_cmp++;
    if (cfg_ready !== 1'b1 || busy !== 1'b0) begin
      n_err++; $display("FAIL ramp_cfg_handshake got ready=%b busy=%b exp 1 0", cfg_ready, busy);
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 1'b1, 1'b0);
      n_cmp++;
      if (dp_scale1 !== exp1[i] || dp_scale0 !== exp0[i]) begin
        n_err++; $display("FAIL ramp_scale beat=%0d got s1=%0d s0=%0d exp s1=%0d s0=%0d", i+1, dp_scale1, dp_scale0, exp1[i], exp0[i]);
      end
      n_cmp++;
      if (dp_tlast !== (i == 3) || dp_tvalid !== 1'b1 || in_tready !== 1'b1 || busy !== 1'b1 || cfg_ready !== 1'b0) begin
        n_err++; $display("FAIL ramp_ctrl beat=%0d got tlast=%b tvalid=%b tready=%b busy=%b ready=%b", i+1, dp_tlast, dp_tvalid, in_tready, busy, cfg_ready);
      end
      n_cmp++;
      if (dp_in0_tdata !== in0_tdata || dp_in1_tdata !== in1_tdata) begin
        n_err++; $display("FAIL ramp_data beat=%0d got %h/%h exp %h/%h", i+1, dp_in0_tdata, dp_in1_tdata, in0_tdata, in1_tdata);
      end
    end
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    n_cmp++;
    if (seg_done !== 1'b1 || cfg_ready !== 1'b1 || busy !== 1'b0 || in_tready !== 1'b0 || dp_tvalid !== 1'b0) begin
      n_err++; $display("FAIL ramp_end got done=%b ready=%b busy=%b tready=%b tvalid=%b exp 1 1 0 0 0", seg_done, cfg_ready, busy, in_tready, dp_tvalid);
    end
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    n_cmp++;
    if (seg_done !== 1'b0) begin
      n_err++; $display("FAIL ramp_done_pulse got=%b exp=0", seg_done);
    end
  endtask

  task automatic test_saturation();
    logic [15:0] exp1 [6] = '{16'd0, 16'd400, 16'd800, 16'd1024, 16'd1024, 16'd1024};
    logic [15:0] exp0 [6] = '{16'd1024, 16'd624, 16'd224, 16'd0, 16'd0, 16'd0};
    do_cfg(16'd6, 16'd400);
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b0, 1'b1, 1'b0);
      n_cmp++;
      if (dp_scale1 !== exp1[i] || dp_scale0 !== exp0[i] || dp_tlast !== (i == 5)) begin
        n_err++; $display("FAIL sat_beat beat=%0d got s1=%0d s0=%0d tlast=%b exp s1=%0d s0=%0d tlast=%b", i+1, dp_scale1, dp_scale0, dp_tlast, exp1[i], exp0[i], (i == 5));
      end
    end
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    n_cmp++;
    if (seg_done !== 1'b1 || busy !== 1'b0) begin
      n_err++; $display("FAIL sat_end got done=%b busy=%b exp 1 0", seg_done, busy);
    end
  endtask

  task automatic test_early_tlast();
    do_cfg(16'd8, 16'd100);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, (i == 2), 1'b1, 1'b0);
      n_cmp++;
      if (dp_scale1 !== 16'(i * 100) || dp_tlast !== (i == 2)) begin
        n_err++; $display("FAIL early_beat beat=%0d got s1=%0d tlast=%b exp s1=%0d tlast=%b", i+1, dp_scale1, dp_tlast, i*100, (i == 2));
      end
    end
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    n_cmp++;
    if (in_tready !== 1'b0 || dp_tvalid !== 1'b0 || busy !== 1'b0 || seg_done !== 1'b1) begin
      n_err++; $display("FAIL early_beat4 got tready=%b tvalid=%b busy=%b done=%b exp 0 0 0 1", in_tready, dp_tvalid, busy, seg_done);
    end
  endtask

  task automatic test_stall();
    logic [31:0] held0;
    do_cfg(16'd4, 16'd256);
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    held0 = in0_tdata;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin
        @(negedge clk); in0_tdata = held0; #1;
      end
      n_cmp++;
      if (in_tready !== 1'b0 || dp_tvalid !== 1'b1 || dp_scale1 !== 16'd256 || dp_scale0 !== 16'd768 || dp_in0_tdata !== held0) begin
        n_err++; $display("FAIL stall_hold cyc=%0d got tready=%b tvalid=%b s1=%0d s0=%0d d0=%h exp 0 1 256 768 %h", i, in_tready, dp_tvalid, dp_scale1, dp_scale0, dp_in0_tdata, held0);
      end
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 1'b1, 1'b0);
      n_cmp++;
      if (in_tready !== 1'b1 || dp_scale1 !== 16'(256 * (i + 1)) || dp_tlast !== (i == 2)) begin
        n_err++; $display("FAIL stall_resume beat=%0d got tready=%b s1=%0d tlast=%b exp 1 %0d %b", i+2, in_tready, dp_scale1, dp_tlast, 256*(i+1), (i == 2));
      end
    end
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    n_cmp++;
    if (seg_done !== 1'b1 || busy !== 1'b0) begin
      n_err++; $display("FAIL stall_end got done=%b busy=%b exp 1 0", seg_done, busy);
    end
  endtask

  task automatic test_abort();
    int pulses;
    // Abort in an idle-beat cycle after two beats.
    do_cfg(16'd8, 16'd256);
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b1);
    n_cmp++;
    if (busy !== 1'b1 || dp_scale1 !== 16'd512) begin
      n_err++; $display("FAIL abort_pre got busy=%b s1=%0d exp 1 512", busy, dp_scale1);
    end
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b0);
      if (seg_done === 1'b1) pulses++;
    end
    n_cmp++;
    if (pulses !== 1 || busy !== 1'b0 || dp_scale1 !== 16'd0) begin
      n_err++; $display("FAIL abort_idle got pulses=%0d busy=%b s1=%0d exp 1 0 0", pulses, busy, dp_scale1);
    end
    // Abort coinciding with accepted beat 2.
    do_cfg(16'd8, 16'd256);
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    n_cmp++;
    if (dp_scale1 !== 16'd0) begin
      n_err++; $display("FAIL abort_restart got s1=%0d exp 0", dp_scale1);
    end
    drive(1'b1, 1'b0, 1'b1, 1'b1);
    n_cmp++;
    if (in_tready !== 1'b1 || dp_tvalid !== 1'b1 || dp_scale1 !== 16'd256 || dp_scale0 !== 16'd768) begin
      n_err++; $display("FAIL abort_beat got tready=%b tvalid=%b s1=%0d s0=%0d exp 1 1 256 768", in_tready, dp_tvalid, dp_scale1, dp_scale0);
    end
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b0);
      if (seg_done === 1'b1) pulses++;
    end
    n_cmp++;
    if (pulses !== 1 || busy !== 1'b0) begin
      n_err++; $display("FAIL abort_with_beat got pulses=%0d busy=%b exp 1 0", pulses, busy);
    end
    do_cfg(16'd1, 16'd256);
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    n_cmp++;
    if (dp_scale1 !== 16'd0 || dp_tlast !== 1'b1) begin
      n_err++; $display("FAIL len1_after_abort got s1=%0d tlast=%b exp 0 1", dp_scale1, dp_tlast);
    end
    drive(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_len0_and_reset();
    int pulses;
    do_cfg(16'd0, 16'd256);
    n_cmp++;
    if (cfg_ready !== 1'b1) begin
      n_err++; $display("FAIL len0_ready got=%b exp=1", cfg_ready);
    end
    drive(1'b1, 1'b0, 1'b1, 1'b1);
    n_cmp++;
    if (busy !== 1'b0 || in_tready !== 1'b0 || dp_tvalid !== 1'b0) begin
      n_err++; $display("FAIL len0_idle got busy=%b tready=%b tvalid=%b exp 0 0 0", busy, in_tready, dp_tvalid);
    end
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b1);
      if (seg_done === 1'b1) pulses++;
    end
    n_cmp++;
    if (pulses !== 0 || busy !== 1'b0) begin
      n_err++; $display("FAIL idle_abort got pulses=%0d busy=%b exp 0 0", pulses, busy);
    end
    do_cfg(16'd4, 16'd256);
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    n_cmp++;
    if (dp_tvalid !== 1'b1 || dp_scale1 !== 16'd256) begin
      n_err++; $display("FAIL rst_pre got tvalid=%b s1=%0d exp 1 256", dp_tvalid, dp_scale1);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({cfg_ready, busy, in_tready, dp_tvalid, dp_tlast, seg_done} !== 6'b100000 || dp_scale1 !== 16'd0 || dp_scale0 !== 16'd1024) begin
      n_err++; $display("FAIL rst_mid_run got ctrl=%b s1=%0d s0=%0d exp 100000 0 1024", {cfg_ready, busy, in_tready, dp_tvalid, dp_tlast, seg_done}, dp_scale1, dp_scale0);
    end
    @(negedge clk); rst_n = 1'b1; in_tvalid = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_saturation();
    test_early_tlast();
    test_stall();
    test_abort();
    test_len0_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/lin1d_weight_sched.md
Name: lin1d_weight_sched

Overview:
- Sequencer for the 1D linear-interpolation datapath: supplies the per-sample weight pair (scale0, scale1) alongside the two complex sample streams.
- A segment is one configured run of samples. Within a segment, scale1 ramps from 0 toward ONE by a programmed step per accepted beat, and scale0 = ONE - scale1.
- Accepts one configuration per segment, gates the stream handshake, and marks segment ends with tlast.
- Sits between the sample source / settings bus and the interpolation multiply-add datapath.

Parameters:
DATA_WIDTH, 16, width of each I/Q component and of each scale word (signed)
CNT_WIDTH, 16, width of segment length and beat counter
ONE, 1024, unity weight in the datapath's scale format; must be < 2^(DATA_WIDTH-1)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
cfg_valid  in  1  configuration offer
cfg_ready  out  1  configuration accepted when valid&ready
cfg_step  in  DATA_WIDTH  unsigned scale1 increment per accepted beat
cfg_len  in  CNT_WIDTH  beats per segment; 0 is illegal
cfg_abort  in  1  terminate current segment
in_tvalid  in  1  input pair valid
in_tlast  in  1  input packet end
in_tready  out  1  input pair accepted
in0_tdata  in  2*DATA_WIDTH  complex sample 0 (I high, Q low)
in1_tdata  in  2*DATA_WIDTH  complex sample 1
dp_tvalid  out  1  to datapath
dp_tlast  out  1  to datapath
dp_tready  in  1  from datapath
dp_scale0  out  DATA_WIDTH  weight for sample 0
dp_scale1  out  DATA_WIDTH  weight for sample 1
dp_in0_tdata  out  2*DATA_WIDTH  pass-through of in0_tdata
dp_in1_tdata  out  2*DATA_WIDTH  pass-through of in1_tdata
busy  out  1  high in RUN
seg_done  out  1  one-cycle pulse after a segment completes or aborts

Behaviour:
- Reset (reset low, asynchronous):
  - State = IDLE; w1 = 0; k = 0; step_r = 0; len_r = 0; seg_done = 0.
  - Combinationally in IDLE: cfg_ready = 1, busy = 0, in_tready = 0, dp_tvalid = 0, dp_tlast = 0, dp_scale1 = 0, dp_scale0 = ONE.
  - Reset release is synchronised internally (two-flop) before the FSM leaves IDLE.
- IDLE:
  - cfg_ready = 1.
  - On cfg_valid & cfg_len != 0: latch step_r = cfg_step and len_r = cfg_len; clear k and w1; go to RUN.
  - cfg_valid with cfg_len == 0: consumed (ready = 1), no state change.
  - No input beats are accepted in IDLE.
- RUN:
  - cfg_ready = 0, busy = 1.
  - dp_tvalid = in_tvalid; in_tready = dp_tready. Pure combinational pass-through, zero latency; data ports pass through unmodified.
  - dp_scale1 = w1; dp_scale0 = ONE - w1. Both are registers, stable while a beat is stalled.
  - last_beat = (k == len_r - 1) or in_tlast. dp_tlast = last_beat.
  - Accepted beat (in_tvalid & dp_tready):
    - k <= k + 1.
    - w1 <= min(w1 + step_r, ONE). The addition is computed at DATA_WIDTH+1 bits, so there is no wrap.
  - Accepted beat with last_beat: go to IDLE and pulse seg_done on the next cycle.
  - in_tlast before len_r beats ends the segment early; dp_tlast is asserted on that beat.
- Abort:
  - cfg_abort in RUN with no beat accepted that cycle: go to IDLE, pulse seg_done, w1 and k cleared.
  - cfg_abort in the same cycle as an accepted beat: the beat completes with its current weights; the FSM then goes to IDLE. Exactly one seg_done pulse.
  - cfg_abort in IDLE: ignored.
- Saturation: w1 holds at ONE once reached; scale0 holds at 0. step_r = 0 gives constant scale1 = 0, scale0 = ONE.
- Back-to-back segments: at least one IDLE cycle between segments (the cfg handshake cycle). The first beat of a new segment has w1 = 0.
- Counter k never exceeds len_r - 1; len_r = 1 gives a single beat with tlast.
- Reset asserted mid-segment: immediate return to IDLE. A partial beat is dropped; dp_tvalid falls asynchronously.

Test Plan:
- Reset, then cfg len=4, step=256, ONE=1024; stream 4 beats with dp_tready=1 -> scale1 = 0,256,512,768; scale0 = 1024,768,512,256; dp_tlast only on beat 4; seg_done pulses the cycle after; cfg_ready returns to 1.
- len=6, step=400 -> scale1 = 0,400,800,1024,1024,1024 (saturation); scale0 never negative.
- len=8, in_tlast on beat 3 -> dp_tlast on beat 3; FSM to IDLE; beat 4 not accepted (in_tready = 0).
- Toggle dp_tready low for 3 cycles mid-segment -> in_tready follows; scale and data held stable; k unchanged; no beat duplicated or lost.
- cfg_abort after 2 beats, and cfg_abort coinciding with accepted beat 2 -> single seg_done in each case; next segment restarts at scale1 = 0.
- cfg_len=0 offered -> ready=1, busy stays 0; then assert reset low mid-RUN -> all outputs at reset values without waiting for a clk edge.
